// File: rtl/spi_bus_ctrl.sv
// Z80 I/O-port front end for spi_master: a data port and a control/status port,
// a chip-select register, fixed-length byte transfers and CPU WAIT stretching.

module spi_bus_ctrl_sync #(
    parameter int             W       = 4,
    parameter logic [W-1:0]   RST_VAL = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

module spi_bus_ctrl #(
    parameter logic [7:0] BASE        = 8'h40,
    parameter int         XFER_CYCLES = 32
) (
    input  logic       CLK1,
    input  logic       RESET_N,
    input  logic [7:0] A,
    input  logic [7:0] D_IN,
    output logic [7:0] D_OUT,
    output logic       D_OE,
    input  logic       IORQ,
    input  logic       RD,
    input  logic       WR,
    input  logic       M1,
    output logic       WAIT_N,
    output logic       SPI_ACTIVE,
    output logic       SPI_SENDING,
    output logic [7:0] SPI_TX,
    input  logic [7:0] SPI_RX
);

    localparam int          CW       = $clog2(XFER_CYCLES);
    localparam logic [CW-1:0] CNT_INIT = CW'(XFER_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SEND, CAPTURE} state_t;

    typedef struct packed {
        logic iorq;
        logic rd;
        logic wr;
        logic m1;
    } bus_ctl_t;

    bus_ctl_t bus_raw, bus_s;

    assign bus_raw = '{iorq: IORQ, rd: RD, wr: WR, m1: M1};

    // All four strobes idle high, so the synchroniser resets to all ones.
    spi_bus_ctrl_sync #(.W(4), .RST_VAL(4'hF)) u_sync (
        .clk   (CLK1),
        .rst_n (RESET_N),
        .d     (bus_raw),
        .q     (bus_s)
    );

    state_t        state;
    logic [CW-1:0] cnt;
    logic          sel, sel_clr, err, rx_valid, wait_pend;
    logic [7:0]    rx_data, pend;
    logic          wr_act_d, rd_act_d;

    logic       qual, wr_act, rd_act, wr_stb, rd0_clr, busy, defer_sel;
    logic [7:0] status;

    assign qual    = !bus_s.iorq && bus_s.m1 && (A[7:1] == BASE[7:1]);
    assign wr_act  = qual && !bus_s.wr;
    assign rd_act  = qual && !bus_s.rd;
    assign wr_stb  = wr_act && !wr_act_d;
    assign rd0_clr = rd_act && !rd_act_d && !A[0];
    assign busy    = (state != IDLE);
    assign status  = {busy, wait_pend, rx_valid, err, 3'b000, sel};

    // A transfer about to launch from pend counts as in flight for select clears;
    // in CAPTURE the deferred clear has already been applied, so the CPU value wins.
    assign defer_sel = (state == SEND) || (state == IDLE && wait_pend);

    assign SPI_ACTIVE = sel;

    always_ff @(posedge CLK1 or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= IDLE;
            cnt         <= '0;
            sel         <= 1'b0;
            sel_clr     <= 1'b0;
            err         <= 1'b0;
            rx_valid    <= 1'b0;
            wait_pend   <= 1'b0;
            rx_data     <= 8'h00;
            pend        <= 8'h00;
            wr_act_d    <= 1'b0;
            rd_act_d    <= 1'b0;
            D_OUT       <= 8'h00;
            D_OE        <= 1'b0;
            WAIT_N      <= 1'b1;
            SPI_SENDING <= 1'b0;
            SPI_TX      <= 8'h00;
        end else begin
            wr_act_d <= wr_act;
            rd_act_d <= rd_act;
            D_OE     <= rd_act;
            D_OUT    <= rd_act ? (A[0] ? status : rx_data) : 8'h00;

            if (rd0_clr)
                rx_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (wait_pend) begin
                        SPI_TX      <= pend;
                        wait_pend   <= 1'b0;
                        WAIT_N      <= 1'b1;
                        SPI_SENDING <= 1'b1;
                        cnt         <= CNT_INIT;
                        state       <= SEND;
                    end
                end
                SEND: begin
                    if (cnt == '0) begin
                        SPI_SENDING <= 1'b0;
                        state       <= CAPTURE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                CAPTURE: begin
                    // Setting rx_valid after the read-clear above lets a same-cycle set win.
                    rx_data  <= SPI_RX;
                    rx_valid <= 1'b1;
                    WAIT_N   <= 1'b1;
                    if (sel_clr) begin
                        sel     <= 1'b0;
                        sel_clr <= 1'b0;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // CPU writes come last so they override the FSM updates made this cycle.
            if (wr_stb) begin
                if (A[0]) begin
                    if (D_IN[4])
                        err <= 1'b0;
                    if (D_IN[0]) begin
                        sel     <= 1'b1;
                        sel_clr <= 1'b0;
                    end else if (defer_sel) begin
                        sel_clr <= 1'b1;
                    end else begin
                        sel     <= 1'b0;
                        sel_clr <= 1'b0;
                    end
                end else if (!sel) begin
                    err <= 1'b1;
                end else if (state == IDLE && !wait_pend) begin
                    SPI_TX      <= D_IN;
                    SPI_SENDING <= 1'b1;
                    cnt         <= CNT_INIT;
                    state       <= SEND;
                end else if (!wait_pend) begin
                    pend      <= D_IN;
                    wait_pend <= 1'b1;
                    WAIT_N    <= 1'b0;
                end
            end
        end
    end

endmodule
